s2mm_packet_arbiter: RTL and testbench

Return-path scheduler that shares the single MCDMA S2MM slave stream between NUM_FIFOS accelerator output FIFOs. It grants one non-empty FIFO at a time in round-robin order and streams a fixed-length packet from it. Each packet carries `tdest` equal to the FIFO index and ends with `tlast`, so the MCDMA routes it to the matching S2MM channel. It mirrors the MM2S-side demux that fans the DMA stream out to the accelerator input FIFOs.

---
 rtl/s2mm_packet_arbiter_if.sv | 15 +
 rtl/s2mm_packet_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_s2mm_packet_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2mm_packet_arbiter_if.sv
// AXI4-Stream return channel from the packet arbiter to the MCDMA S2MM port.
// master: arbiter side (drives data/dest/last/valid), slave: DMA side (drives ready).
interface s2mm_packet_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tdest, tlast, tvalid, input tready);
  modport slave  (input tdata, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/s2mm_packet_arbiter.sv
// Round-robin packet arbiter sharing one MCDMA S2MM stream between NUM_FIFOS
// FWFT source FIFOs. Each grant streams pkt_len words with tdest = FIFO index
// and tlast on the final beat.
// Optional macro S2MM_PACKET_ARBITER_OUTREG_EN: registers the stream outputs
// through a 2-entry skid buffer so tready never reaches fifo_rden combinationally.
//
// state  | meaning
// IDLE   | no packet owned; round-robin search for an eligible FIFO
// STREAM | packet owned by 'grant' until its tlast beat has been accepted
module s2mm_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_FIFOS       = 2,
  parameter int PKT_LEN_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  s2mm_packet_arbiter_if.master                dst_axis,
  output logic [NUM_FIFOS-1:0]                 fifo_rden,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_FIFOS*PKT_LEN_WIDTH-1:0]   pkt_len,
  output logic                                 busy,
  output logic [NUM_FIFOS-1:0]                 active_ch
);
  localparam int IDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]               state;
  logic [IDX_W-1:0]         rr, grant, pick, cand, grant_next;
  logic                     found;
  logic [PKT_LEN_WIDTH-1:0] len, beat_cnt;
  logic [NUM_FIFOS-1:0]     elig;
  logic [FIFO_DATA_WIDTH-1:0] data_arr [NUM_FIFOS];
  logic [PKT_LEN_WIDTH-1:0]   len_arr  [NUM_FIFOS];
  logic [FIFO_DATA_WIDTH-1:0] head;
  logic                     head_avail, last_word;

  // Unpack the flat FIFO buses and flag FIFOs that may start a packet.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      data_arr[i] = fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
      len_arr[i]  = pkt_len[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
      elig[i]     = !fifo_empty[i] && (len_arr[i] != '0);
    end
  end

  // First eligible FIFO at or after rr, wrapping; scanned high-to-low so the nearest wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr) + k) % NUM_FIFOS);
      if (elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Per-packet helpers derived from the latched grant.
  always_comb begin
    head       = data_arr[grant];
    head_avail = !fifo_empty[grant];
    last_word  = (beat_cnt == len - 1'b1);
    grant_next = (grant == IDX_W'(NUM_FIFOS - 1)) ? '0 : grant + 1'b1;
    busy       = (state == STREAM);
    active_ch  = busy ? (NUM_FIFOS'(1) << grant) : '0;
  end

`ifdef S2MM_PACKET_ARBITER_OUTREG_EN
  // Skid buffer: popped words wait here; the source side only looks at occupancy.
  logic [FIFO_DATA_WIDTH-1:0] sk_data [2];
  logic [1:0]                 sk_last;
  logic                       sk_wr, sk_rd, src_done, pop, out_hs;
  logic [1:0]                 sk_cnt;

  // Pop while the packet still has source words and the skid has a free slot.
  always_comb begin
    pop                = busy && !src_done && head_avail && (sk_cnt != 2'd2);
    fifo_rden          = pop ? active_ch : '0;
    dst_axis.tvalid    = (sk_cnt != 2'd0);
    dst_axis.tdata     = dst_axis.tvalid ? AXIS_DATA_WIDTH'(sk_data[sk_rd]) : '0;
    dst_axis.tlast     = dst_axis.tvalid && sk_last[sk_rd];
    dst_axis.tdest     = busy ? AXIS_DEST_WIDTH'(grant) : '0;
    out_hs             = dst_axis.tvalid && dst_axis.tready;
  end

  // Skid storage and occupancy; entries stay put until accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_data[0] <= '0;
      sk_data[1] <= '0;
      sk_last    <= '0;
      sk_wr      <= 1'b0;
      sk_rd      <= 1'b0;
      sk_cnt     <= 2'd0;
    end else begin
      if (pop) begin
        sk_data[sk_wr] <= head;
        sk_last[sk_wr] <= last_word;
        sk_wr          <= ~sk_wr;
      end
      if (out_hs) sk_rd <= ~sk_rd;
      sk_cnt <= sk_cnt + {1'b0, pop} - {1'b0, out_hs};
    end
  end

  // Grant/stream FSM; the packet is released only once its tlast beat leaves the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      grant    <= '0;
      len      <= '0;
      beat_cnt <= '0;
      src_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant    <= pick;
          len      <= len_arr[pick];
          beat_cnt <= '0;
          src_done <= 1'b0;
          state    <= STREAM;
        end
        default: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_word) src_done <= 1'b1;
          end
          if (out_hs && sk_last[sk_rd]) begin
            rr    <= grant_next;
            state <= IDLE;
          end
        end
      endcase
    end
  end
`else
  // Combinational output path straight from the granted FIFO head.
  always_comb begin
    dst_axis.tvalid = busy && head_avail;
    dst_axis.tdata  = busy ? AXIS_DATA_WIDTH'(head) : '0;
    dst_axis.tdest  = busy ? AXIS_DEST_WIDTH'(grant) : '0;
    dst_axis.tlast  = busy && last_word;
    fifo_rden       = (dst_axis.tvalid && dst_axis.tready) ? active_ch : '0;
  end

  // Grant/stream FSM; each accepted beat advances the count, tlast releases the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      grant    <= '0;
      len      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant    <= pick;
          len      <= len_arr[pick];
          beat_cnt <= '0;
          state    <= STREAM;
        end
        default: if (dst_axis.tvalid && dst_axis.tready) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_word) begin
            rr    <= grant_next;
            state <= IDLE;
          end
        end
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Scoreboard bench for s2mm_packet_arbiter: FWFT FIFOs modelled as queues,
// a packet-level reference model predicts grants and beats, a negedge monitor compares.
module tb_s2mm_packet_arbiter;
  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int FW    = 32;
  localparam int DESTW = 4;
  localparam int PW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    fifo_rden, fifo_empty, active_ch;
  logic [N*FW-1:0] fifo_data;
  logic [N*PW-1:0] pkt_len;
  logic            busy;

  s2mm_packet_arbiter_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW)) axis ();

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH(DW), .FIFO_DATA_WIDTH(FW), .AXIS_DEST_WIDTH(DESTW),
    .NUM_FIFOS(N), .PKT_LEN_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .dst_axis(axis),
    .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .pkt_len(pkt_len), .busy(busy), .active_ch(active_ch)
  );

  logic [FW-1:0] fifo_q [N][$];
  logic [FW-1:0] ref_q  [N][$];
  int ptr [N];
  int checks = 0;
  int errors = 0;

  // reference model / monitor state
  bit m_busy, m_pend;
  int m_fifo, m_len, m_beat, m_rr, hs_count;
  int grant_log [$];
  logic [N-1:0] pop_req;
  logic prev_stall, prev_last;
  logic [DW-1:0] prev_data;
  logic [DESTW-1:0] prev_dest;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor + reference model
  always @(negedge clk) begin
    bit cur_idle;
    logic hs;
    logic [N-1:0] onehot;
    logic [FW-1:0] exp_data;
    int idx;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_rr = 0; m_beat = 0;
      for (int i = 0; i < N; i++) ptr[i] = 0;
      pop_req = '0; prev_stall = 0;
    end else begin
      cur_idle = !m_busy && !m_pend;
      if (m_pend) begin m_busy = 1; m_pend = 0; end
      hs = axis.tvalid && axis.tready;
      if (m_busy) begin
        onehot = N'(1) << m_fifo;
        chk("busy", busy, 1);
        chk("active_ch", active_ch, onehot);
      end else begin
        chk("busy_idle", busy, 0);
        chk("active_ch_idle", active_ch, 0);
        chk("tvalid_idle", axis.tvalid, 0);
      end
      if (prev_stall) begin
        chk("stall_tvalid", axis.tvalid, 1);
        chk("stall_tdata", axis.tdata, prev_data);
        chk("stall_tlast", axis.tlast, prev_last);
        chk("stall_tdest", axis.tdest, prev_dest);
      end
      if (hs && m_busy) begin
        exp_data = (ptr[m_fifo] < ref_q[m_fifo].size()) ? ref_q[m_fifo][ptr[m_fifo]] : 'x;
        chk("beat_tdest", axis.tdest, m_fifo);
        chk("beat_tdata", axis.tdata, exp_data);
        chk("beat_tlast", axis.tlast, (m_beat == m_len - 1));
        ptr[m_fifo]++;
        m_beat++;
        hs_count++;
        if (m_beat == m_len) begin
          m_busy = 0;
          m_rr = (m_fifo + 1) % N;
        end
      end
      chk("rden_not_granted", fifo_rden & ~active_ch, 0);
      chk("rden_on_empty", fifo_rden & fifo_empty, 0);
`ifndef S2MM_PACKET_ARBITER_OUTREG_EN
      chk("rden_vs_handshake", fifo_rden, hs ? active_ch : '0);
`endif
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      prev_dest  = axis.tdest;
      pop_req    = fifo_rden;
      if (cur_idle) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (!m_pend && fifo_q[idx].size() != 0 && pkt_len[idx*PW +: PW] != '0) begin
            m_pend = 1;
            m_fifo = idx;
            m_len  = int'(pkt_len[idx*PW +: PW]);
            m_beat = 0;
            grant_log.push_back(idx);
          end
        end
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (fifo_q[i].size() == 0);
      fifo_data[i*FW +: FW] = fifo_empty[i] ? (32'hBAD0_0000 + FW'(i)) : fifo_q[i][0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop_req[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    refresh();
  endtask

  task automatic push(input int i, input logic [FW-1:0] d);
    fifo_q[i].push_back(d);
    ref_q[i].push_back(d);
    refresh();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      fifo_q[i].delete();
      ref_q[i].delete();
    end
    refresh();
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit done = 0;
    for (int c = 0; c < bound && !done; c++) begin
      step();
      done = (fifo_q[0].size() == 0) && (fifo_q[1].size() == 0) && !m_busy && !m_pend && !busy;
    end
    chk(name, done, 1);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    flush();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int base, tgt;
    logic tr_pat [8];
    tr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    axis.tready = 1'b0;
    pkt_len = {16'd4, 16'd4};
    flush();
    repeat (3) step();
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_ch", active_ch, 0);
    chk("rst_rden", fifo_rden, 0);
    rst = 1'b0;
    axis.tready = 1'b1;
    repeat (2) step();

    // single packet from FIFO0 and first-beat latency
    for (int w = 0; w < 4; w++) push(0, 32'h10 + FW'(w));
    @(negedge clk);
    chk("latency_cycle_n", axis.tvalid, 0);
    step();
    @(negedge clk);
`ifdef S2MM_PACKET_ARBITER_OUTREG_EN
    chk("latency_cycle_n1", axis.tvalid, 0);
    step();
    @(negedge clk);
    chk("latency_cycle_n2", axis.tvalid, 1);
`else
    chk("latency_cycle_n1", axis.tvalid, 1);
`endif
    chk("first_tdata", axis.tdata, 32'h10);
    wait_idle("drain_single", 40);

    // two full FIFOs alternate 0,1,0,1
    do_reset();
    base = grant_log.size();
    for (int w = 0; w < 8; w++) begin
      push(0, 32'h100 + FW'(w));
      push(1, 32'h200 + FW'(w));
    end
    wait_idle("drain_alternate", 80);
    chk("alt_grants", grant_log.size() - base, 4);
    for (int g = 0; g < 4; g++)
      if (base + g < grant_log.size()) chk("alt_order", grant_log[base + g], g % 2);

    // tready stall pattern mid-packet
    for (int w = 0; w < 8; w++) push(0, 32'h300 + FW'(w));
    for (int c = 0; c < 24; c++) begin
      axis.tready = tr_pat[c % 8];
      step();
    end
    axis.tready = 1'b1;
    wait_idle("drain_stall", 60);

    // granted FIFO1 runs dry after 2 beats while FIFO0 waits
    base = grant_log.size();
    push(1, 32'h400); push(1, 32'h401);
    for (int w = 0; w < 8; w++) push(0, 32'h500 + FW'(w));
    repeat (10) step();
    chk("dry_holds_grant", active_ch, 2'b10);
    push(1, 32'h402); push(1, 32'h403);
    wait_idle("drain_dry", 80);
    if (grant_log.size() > base) chk("dry_first_grant", grant_log[base], 1);

    // pkt_len 0 keeps FIFO0 out of arbitration
    pkt_len[0 +: PW] = '0;
    base = grant_log.size();
    for (int w = 0; w < 3; w++) push(0, 32'h600 + FW'(w));
    repeat (15) step();
    chk("len0_no_grant", busy, 0);
    for (int w = 0; w < 4; w++) push(1, 32'h700 + FW'(w));
    repeat (15) step();
    chk("len0_only_fifo1", grant_log.size() - base, 1);
    pkt_len[0 +: PW] = 16'd3;
    wait_idle("drain_len0", 60);

    // reset mid-packet
    pkt_len = {16'd4, 16'd4};
    push(0, 32'h800); push(0, 32'h801); push(0, 32'h802); push(0, 32'h803);
    tgt = hs_count + 2;
    for (int c = 0; c < 40 && hs_count < tgt; c++) step();
    chk("midrst_reached", hs_count >= tgt, 1);
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", axis.tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_active_ch", active_ch, 0);
    chk("midrst_rden", fifo_rden, 0);
    flush();
    step();
    step();
    rst = 1'b0;
    step();
    base = grant_log.size();
    for (int w = 0; w < 4; w++) begin
      push(0, 32'h900 + FW'(w));
      push(1, 32'hA00 + FW'(w));
    end
    wait_idle("drain_after_rst", 80);
    if (grant_log.size() > base) chk("post_rst_grant", grant_log[base], 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      axis.tready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(2) == 0 && fifo_q[i].size() < 16) push(i, $urandom);
        if ($urandom_range(40) == 0) pkt_len[i*PW +: PW] = PW'($urandom_range(5));
      end
    end
    pkt_len = {16'd1, 16'd1};
    axis.tready = 1'b1;
    wait_idle("drain_random", 600);
    for (int i = 0; i < N; i++) chk("all_words_delivered", ptr[i], ref_q[i].size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
